// File: rtl/gpu_pkg.sv
// Shared GPU definitions: data-cache geometry defaults, arbiter state and requester ids.
package gpu_pkg;

   localparam int unsigned DATA_CACHE_WIDTH = 16;
   localparam int unsigned WORDS_PER_LINE   = 6;

   typedef enum logic [0:0] {
      ARB_RR    = 1'b0,
      ARB_LOCK0 = 1'b1
   } arb_state_t;

   localparam logic REQ_MEM  = 1'b0;
   localparam logic REQ_DISP = 1'b1;

endpackage

// File: rtl/data_cache_arbiter_if.sv
// Bundle of requester handshakes and the data-cache BRAM port seen by the arbiter.
interface data_cache_arbiter_if #(
   parameter int unsigned DATA_CACHE_WIDTH = gpu_pkg::DATA_CACHE_WIDTH,
   parameter int unsigned WORDS_PER_LINE   = gpu_pkg::WORDS_PER_LINE,
   parameter int unsigned DATA_CACHE_DEPTH = 4096
);
   localparam int unsigned LINE_WIDTH = DATA_CACHE_WIDTH * WORDS_PER_LINE;
   localparam int unsigned ADDR_WIDTH = $clog2(DATA_CACHE_DEPTH);

   logic                  req0_valid_in;
   logic                  req0_we_in;
   logic                  req0_lock_in;
   logic [ADDR_WIDTH-1:0] req0_addr_in;
   logic [LINE_WIDTH-1:0] req0_data_in;
   logic                  req0_ready_out;
   logic                  rsp0_valid_out;
   logic [LINE_WIDTH-1:0] rsp0_data_out;

   logic                  req1_valid_in;
   logic [ADDR_WIDTH-1:0] req1_addr_in;
   logic                  req1_ready_out;
   logic                  rsp1_valid_out;
   logic [LINE_WIDTH-1:0] rsp1_data_out;

   logic                  bram_en_out;
   logic                  bram_we_out;
   logic [ADDR_WIDTH-1:0] bram_addr_out;
   logic [LINE_WIDTH-1:0] bram_din_out;
   logic [LINE_WIDTH-1:0] bram_dout_in;

   modport slave (
      input  req0_valid_in, req0_we_in, req0_lock_in, req0_addr_in, req0_data_in,
      output req0_ready_out, rsp0_valid_out, rsp0_data_out,
      input  req1_valid_in, req1_addr_in,
      output req1_ready_out, rsp1_valid_out, rsp1_data_out,
      output bram_en_out, bram_we_out, bram_addr_out, bram_din_out,
      input  bram_dout_in
   );

   modport master (
      output req0_valid_in, req0_we_in, req0_lock_in, req0_addr_in, req0_data_in,
      input  req0_ready_out, rsp0_valid_out, rsp0_data_out,
      output req1_valid_in, req1_addr_in,
      input  req1_ready_out, rsp1_valid_out, rsp1_data_out,
      input  bram_en_out, bram_we_out, bram_addr_out, bram_din_out,
      output bram_dout_in
   );

endinterface

// File: rtl/rsp_tag_pipe.sv
// Fixed-depth {valid, id} shift register that mirrors the BRAM read latency.
module rsp_tag_pipe #(
   parameter int unsigned DEPTH = 2
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic push_valid,
   input  logic push_id,
   output logic pop_valid,
   output logic pop_id
);

   logic [DEPTH-1:0] valid_q;
   logic [DEPTH-1:0] id_q;

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         valid_q <= '0;
         id_q    <= '0;
      end else begin
         valid_q[0] <= push_valid;
         id_q[0]    <= push_id;
         for (int i = 1; i < int'(DEPTH); i++) begin
            valid_q[i] <= valid_q[i-1];
            id_q[i]    <= id_q[i-1];
         end
      end
   end

   assign pop_valid = valid_q[DEPTH-1];
   assign pop_id    = id_q[DEPTH-1];

endmodule

// File: rtl/data_cache_arbiter.sv
// Round-robin arbiter for the single data-cache BRAM port, with a requester-0 burst lock
// and a latency-matched tag pipe that routes read data back to the issuing requester.
module data_cache_arbiter #(
   parameter int unsigned DATA_CACHE_WIDTH = gpu_pkg::DATA_CACHE_WIDTH,
   parameter int unsigned WORDS_PER_LINE   = gpu_pkg::WORDS_PER_LINE,
   parameter int unsigned DATA_CACHE_DEPTH = 4096,
   parameter int unsigned READ_LATENCY     = 2
) (
   input logic                 clk_in,
   input logic                 rst_in,
   data_cache_arbiter_if.slave bus
);
   import gpu_pkg::*;

   localparam int unsigned LINE_WIDTH = DATA_CACHE_WIDTH * WORDS_PER_LINE;
   localparam int unsigned ADDR_WIDTH = $clog2(DATA_CACHE_DEPTH);

   arb_state_t            state_q, state_d;
   logic                  last_grant_q, last_grant_d;
   logic                  grant0, grant1;
   logic                  pipe_valid, pipe_id;
   logic                  rsp0_hit, rsp1_hit;
   logic [LINE_WIDTH-1:0] hold0_q, hold1_q;
   logic [ADDR_WIDTH-1:0] grant_addr;

   // last_grant_q is always REQ_MEM while locked, so the lock-release cycle arbitrates as plain RR.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_in) begin
         grant0 = 1'b0;
      end else if (state_q == ARB_LOCK0 && bus.req0_lock_in) begin
         grant0 = bus.req0_valid_in;
      end else if (bus.req0_valid_in && bus.req1_valid_in) begin
         grant0 = (last_grant_q == REQ_DISP);
         grant1 = !grant0;
      end else begin
         grant0 = bus.req0_valid_in;
         grant1 = bus.req1_valid_in;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      if (grant0) begin
         last_grant_d = REQ_MEM;
      end else if (grant1) begin
         last_grant_d = REQ_DISP;
      end
      if (grant0 && bus.req0_lock_in) begin
         state_d = ARB_LOCK0;
      end else if (!bus.req0_lock_in) begin
         state_d = ARB_RR;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         state_q      <= ARB_RR;
         last_grant_q <= REQ_DISP;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign grant_addr = grant1 ? bus.req1_addr_in : bus.req0_addr_in;

   always_comb begin
      bus.req0_ready_out = grant0;
      bus.req1_ready_out = grant1;
      bus.bram_en_out    = grant0 | grant1;
      bus.bram_we_out    = grant0 & bus.req0_we_in;
      bus.bram_addr_out  = (grant0 | grant1) ? grant_addr : '0;
      bus.bram_din_out   = grant0 ? bus.req0_data_in : '0;
   end

   rsp_tag_pipe #(
      .DEPTH(READ_LATENCY)
   ) u_rsp_tag_pipe (
      .clk_in    (clk_in),
      .rst_in    (rst_in),
      .push_valid((grant0 && !bus.req0_we_in) || grant1),
      .push_id   (grant1),
      .pop_valid (pipe_valid),
      .pop_id    (pipe_id)
   );

   assign rsp0_hit = pipe_valid && (pipe_id == REQ_MEM);
   assign rsp1_hit = pipe_valid && (pipe_id == REQ_DISP);

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         hold0_q <= '0;
         hold1_q <= '0;
      end else begin
         if (rsp0_hit) hold0_q <= bus.bram_dout_in;
         if (rsp1_hit) hold1_q <= bus.bram_dout_in;
      end
   end

   always_comb begin
      bus.rsp0_valid_out = rsp0_hit;
      bus.rsp1_valid_out = rsp1_hit;
      bus.rsp0_data_out  = rsp0_hit ? bus.bram_dout_in : hold0_q;
      bus.rsp1_data_out  = rsp1_hit ? bus.bram_dout_in : hold1_q;
   end

endmodule

// File: tb/tb_data_cache_arbiter.sv
// Directed bench for data_cache_arbiter with a 2-cycle read-first BRAM model and a
// response scoreboard keyed on the cycle each read result is due.
module tb_data_cache_arbiter;
   import gpu_pkg::*;

   localparam int unsigned LW    = 96;
   localparam int unsigned AW    = 12;
   localparam int unsigned DEPTH = 4096;

   typedef struct {
      logic          id;
      logic [LW-1:0] data;
      int unsigned   due;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          rst_q;
   logic          mon_en;
   int unsigned   cyc;
   int unsigned   vectors;
   int unsigned   errors;
   exp_t          sb_q[$];
   exp_t          e;
   logic          ev0, ev1;
   logic [LW-1:0] last0, last1;
   logic [LW-1:0] shadow [0:DEPTH-1];
   logic [LW-1:0] bram [0:DEPTH-1];
   logic [LW-1:0] rd_stage, dout_q;

   always #5 clk = ~clk;

   data_cache_arbiter_if bus_if ();

   data_cache_arbiter #(
      .DATA_CACHE_WIDTH(16),
      .WORDS_PER_LINE  (6),
      .DATA_CACHE_DEPTH(DEPTH),
      .READ_LATENCY    (2)
   ) dut (
      .clk_in(clk),
      .rst_in(rst),
      .bus   (bus_if)
   );

   function automatic logic [LW-1:0] pat(input int unsigned a, input logic [15:0] base);
      logic [LW-1:0] r;
      for (int i = 0; i < 6; i++) r[i*16 +: 16] = base + 16'(a * 16) + 16'(i);
      return r;
   endfunction

   // Read-first BRAM with a registered output: dout is valid two cycles after enable.
   always @(posedge clk) begin
      if (bus_if.bram_en_out) begin
         rd_stage <= bram[bus_if.bram_addr_out];
         if (bus_if.bram_we_out) bram[bus_if.bram_addr_out] <= bus_if.bram_din_out;
      end
      dout_q <= rd_stage;
   end
   assign bus_if.bram_dout_in = dout_q;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= rst;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         ev0 = 1'b0;
         ev1 = 1'b0;
         if (rst_q) begin
            last0 = '0;
            last1 = '0;
         end
         if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            if (e.id) begin
               ev1 = 1'b1;
               last1 = e.data;
            end else begin
               ev0 = 1'b1;
               last0 = e.data;
            end
         end
         vectors++;
         assert (bus_if.rsp0_valid_out === ev0) else begin
            errors++;
            $error("FAIL rsp0_valid cyc %0d: got %b expected %b", cyc, bus_if.rsp0_valid_out, ev0);
         end
         vectors++;
         assert (bus_if.rsp1_valid_out === ev1) else begin
            errors++;
            $error("FAIL rsp1_valid cyc %0d: got %b expected %b", cyc, bus_if.rsp1_valid_out, ev1);
         end
         vectors++;
         assert (bus_if.rsp0_data_out === last0) else begin
            errors++;
            $error("FAIL rsp0_data cyc %0d: got %h expected %h", cyc, bus_if.rsp0_data_out, last0);
         end
         vectors++;
         assert (bus_if.rsp1_data_out === last1) else begin
            errors++;
            $error("FAIL rsp1_data cyc %0d: got %h expected %h", cyc, bus_if.rsp1_data_out, last1);
         end
         if (!rst && bus_if.req0_valid_in && bus_if.req0_ready_out) begin
            if (bus_if.req0_we_in) shadow[bus_if.req0_addr_in] = bus_if.req0_data_in;
            else sb_q.push_back('{id: REQ_MEM, data: shadow[bus_if.req0_addr_in], due: cyc + 2});
         end
         if (!rst && bus_if.req1_valid_in && bus_if.req1_ready_out) begin
            sb_q.push_back('{id: REQ_DISP, data: shadow[bus_if.req1_addr_in], due: cyc + 2});
         end
         if (rst) sb_q.delete();
      end
   end

   task automatic cycle(input logic v0, input logic we0, input logic lk0,
                        input logic [AW-1:0] a0, input logic [LW-1:0] d0,
                        input logic v1, input logic [AW-1:0] a1,
                        input logic er0, input logic er1, input string tag);
      logic exp_en, exp_we;
      bus_if.req0_valid_in = v0;
      bus_if.req0_we_in    = we0;
      bus_if.req0_lock_in  = lk0;
      bus_if.req0_addr_in  = a0;
      bus_if.req0_data_in  = d0;
      bus_if.req1_valid_in = v1;
      bus_if.req1_addr_in  = a1;
      exp_en = (v0 && er0) || (v1 && er1);
      exp_we = v0 && er0 && we0;
      @(negedge clk);
      vectors++;
      assert (bus_if.req0_ready_out === er0) else begin
         errors++;
         $error("FAIL %s ready0: got %b expected %b", tag, bus_if.req0_ready_out, er0);
      end
      vectors++;
      assert (bus_if.req1_ready_out === er1) else begin
         errors++;
         $error("FAIL %s ready1: got %b expected %b", tag, bus_if.req1_ready_out, er1);
      end
      vectors++;
      assert (bus_if.bram_en_out === exp_en && bus_if.bram_we_out === exp_we) else begin
         errors++;
         $error("FAIL %s bram en/we: got %b/%b expected %b/%b", tag, bus_if.bram_en_out,
                bus_if.bram_we_out, exp_en, exp_we);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, "idle");
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
   endtask

   initial begin
      vectors = 0;
      errors  = 0;
      cyc     = 0;
      mon_en  = 1'b0;
      last0   = '0;
      last1   = '0;
      for (int a = 0; a < int'(DEPTH); a++) begin
         bram[a]   = pat(a, 16'hABCD);
         shadow[a] = pat(a, 16'hABCD);
      end
      rst = 1'b1;
      bus_if.req0_valid_in = 1'b0;
      bus_if.req0_we_in    = 1'b0;
      bus_if.req0_lock_in  = 1'b0;
      bus_if.req0_addr_in  = '0;
      bus_if.req0_data_in  = '0;
      bus_if.req1_valid_in = 1'b0;
      bus_if.req1_addr_in  = '0;
      @(posedge clk);
      #1;
      mon_en = 1'b1;
      do_reset();

      // Single read by requester 0.
      cycle(1'b1, 1'b0, 1'b0, 12'd5, '0, 1'b0, '0, 1'b1, 1'b0, "single_rd");
      idle(3);

      // Contention: fresh reset so requester 0 wins the first tie, then strict alternation.
      do_reset();
      for (int i = 0; i < 6; i++)
         cycle(1'b0 | 1'b1, 1'b0, 1'b0, 12'd1, '0, 1'b1, 12'd2,
               logic'(i % 2 == 0), logic'(i % 2 == 1), "contend");
      idle(3);

      // Lock: four writes with requester 1 starved, then requester 1 granted on release.
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 1'b1, 1'b1, AW'(10 + i), pat(10 + i, 16'h5A00), 1'b1, 12'd20,
               1'b1, 1'b0, "lock_wr");
      cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 12'd20, 1'b0, 1'b1, "lock_release");
      for (int i = 0; i < 4; i++)
         cycle(1'b1, 1'b0, 1'b0, AW'(10 + i), '0, 1'b0, '0, 1'b1, 1'b0, "lock_rdback");
      idle(3);
      for (int i = 0; i < 4; i++) begin
         vectors++;
         assert (bram[10 + i] === pat(10 + i, 16'h5A00)) else begin
            errors++;
            $error("FAIL lock_bram[%0d]: got %h expected %h", 10 + i, bram[10 + i],
                   pat(10 + i, 16'h5A00));
         end
      end

      // Write then read the same line on the next cycle.
      cycle(1'b1, 1'b1, 1'b0, 12'd7, pat(7, 16'h1234), 1'b0, '0, 1'b1, 1'b0, "wr7");
      cycle(1'b1, 1'b0, 1'b0, 12'd7, '0, 1'b0, '0, 1'b1, 1'b0, "rd7");
      idle(3);

      // Reset with a requester-1 read in flight; ready must stay low during reset.
      cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, 12'd3, 1'b0, 1'b1, "rst_inflight");
      rst = 1'b1;
      cycle(1'b1, 1'b0, 1'b0, 12'd4, '0, 1'b1, 12'd6, 1'b0, 1'b0, "rst_ready");
      cycle(1'b1, 1'b0, 1'b0, 12'd4, '0, 1'b1, 12'd6, 1'b0, 1'b0, "rst_ready");
      rst = 1'b0;
      cycle(1'b1, 1'b0, 1'b0, 12'd4, '0, 1'b1, 12'd6, 1'b1, 1'b0, "post_rst_tie");
      idle(3);

      // Full-throughput streaming reads by requester 1.
      for (int i = 0; i < 16; i++)
         cycle(1'b0, 1'b0, 1'b0, '0, '0, 1'b1, AW'(i), 1'b0, 1'b1, "stream");
      idle(3);

      vectors++;
      assert (sb_q.size() == 0) else begin
         errors++;
         $error("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/data_cache_arbiter.md
Name: data_cache_arbiter

Overview:
- Shares the single data-cache BRAM port between two requesters: requester 0 is the memory module (WRITEB/WRITE reads, SENDL/LOADB writes, driven by controller instructions); requester 1 is the frame/HDMI readout path (reads only).
- Performs round-robin arbitration, supports a requester-0 burst lock, and tracks the fixed BRAM read latency so that each read response returns to the correct requester.
- Sits between the memory module, the HDMI reader and the data-cache xilinx_true_dual_port_read_first_2_clock_ram instance, which is configured HIGH_PERFORMANCE and so has a 2-cycle read.

Parameters:
- DATA_CACHE_WIDTH, 16, bits per fixed-point word.
- WORDS_PER_LINE, 6, words per cache line; LINE_WIDTH = DATA_CACHE_WIDTH*WORDS_PER_LINE.
- DATA_CACHE_DEPTH, 4096, lines in the cache; ADDR_WIDTH = $clog2(DATA_CACHE_DEPTH).
- READ_LATENCY, 2, cycles from BRAM enable to valid dout.

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous, active-high reset
- req0_valid_in  in  1  requester 0 has an access
- req0_we_in  in  1  1 = write, 0 = read
- req0_lock_in  in  1  hold the grant on requester 0 while asserted
- req0_addr_in  in  ADDR_WIDTH  line address
- req0_data_in  in  LINE_WIDTH  write data
- req0_ready_out  out  1  access accepted this cycle
- rsp0_valid_out  out  1  read data valid
- rsp0_data_out  out  LINE_WIDTH  read data
- req1_valid_in  in  1  requester 1 read request
- req1_addr_in  in  ADDR_WIDTH  line address
- req1_ready_out  out  1  read accepted this cycle
- rsp1_valid_out  out  1  read data valid
- rsp1_data_out  out  LINE_WIDTH  read data
- bram_en_out  out  1  BRAM port enable
- bram_we_out  out  1  BRAM write enable
- bram_addr_out  out  ADDR_WIDTH  BRAM address
- bram_din_out  out  LINE_WIDTH  BRAM write data
- bram_dout_in  in  LINE_WIDTH  BRAM read data, READ_LATENCY after enable

Behaviour:
- Clock and reset: one clock, clk_in; reset rst_in is synchronous and active-high.
- Handshake:
  - A transfer occurs when valid && ready in the same cycle.
  - ready is combinational from the valid inputs and the arbiter state.
  - At most one ready is high per cycle.
  - Requesters hold addr/data/we stable until ready.
- BRAM drive (combinational from the granted requester):
  - bram_en_out = any transfer.
  - bram_we_out = granted is 0 && req0_we_in.
  - addr/din come from the granted requester.
  - When there is no grant, en=0 and we=0.
- FSM state RR:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester that was not granted last (last_grant register; reset value 1, so requester 0 wins the first tie).
  - Entering LOCK0: on a req0 transfer with req0_lock_in=1.
- FSM state LOCK0:
  - Only requester 0 can be granted; req1_ready_out=0.
  - Leaving: the first cycle req0_lock_in=0 returns to RR, and arbitration that cycle is normal RR with last_grant=0.
  - Lock deasserted with no req0 valid also returns to RR.
- Response pipeline:
  - A READ_LATENCY-deep shift register of {valid, id} entries.
  - Push {1, id} on a read transfer; push {0, x} on a write or idle cycle.
  - At the pipe output: rspN_valid_out=1 exactly READ_LATENCY cycles after the read transfer, and rspN_data_out=bram_dout_in for that same cycle.
  - rspN_data_out is held from the last response when not valid.
  - Back-to-back reads at full throughput: one per cycle, responses in order.
- Write-then-read to the same address on consecutive cycles returns the new data; this follows from BRAM read-first ordering because the accesses are in different cycles.
- No response backpressure: requesters must always accept responses.
- Reset (including mid-operation):
  - State RR, last_grant=1, pipe cleared.
  - rsp0/rsp1_valid_out=0 from the cycle after reset is sampled.
  - rsp data=0.
  - In-flight reads are dropped, never delivered.
  - ready outputs are 0 while rst_in=1.

Decomposition:
- Shared package (gpu_pkg): arb_state_t enum {ARB_RR, ARB_LOCK0}, requester id constants REQ_MEM=0 and REQ_DISP=1, and the DATA_CACHE_WIDTH/WORDS_PER_LINE defaults.
- One natural sub-module: rsp_tag_pipe, a parameterised READ_LATENCY-deep valid/id shift register with synchronous clear.

Test Plan:
1. Single read: req0 read addr 5 (BRAM[5]=0xABCD pattern) -> ready0 high the same cycle, rsp0_valid exactly 2 cycles later with matching data, rsp1_valid stays 0.
2. Contention: both valid for 6 cycles, req0 addr 1, req1 addr 2 -> grants alternate 0,1,0,1,0,1 starting with 0; responses alternate with 2-cycle offset.
3. Lock: req0 lock for 4 writes to addrs 10..13 while req1 is valid -> req1_ready stays 0 for all 4; on the cycle lock drops, req1 is granted; BRAM 10..13 contain the written data.
4. Write-then-read: write 0x1234-pattern to addr 7, read addr 7 next cycle -> rsp0 data equals the written pattern.
5. Reset mid-flight: issue a req1 read, assert rst_in one cycle later -> no rsp1_valid ever appears; after release, the first tie is granted to requester 0.
6. Throughput: req1 reads addrs 0..15 continuously -> 16 consecutive ready cycles and 16 consecutive responses, in order, starting at cycle +2.
